// File: rtl/vram_wb_writer.sv
// Buffered Wishbone classic single-write master: queues VRAM write requests in a FIFO
// and issues one write cycle per entry, finishing each on ack or aborting it on timeout.
module vram_wb_writer #(
    parameter int ADDR_W     = 27,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                              clk_100MHz,
    input  logic                              reset_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic [ADDR_W-1:0]                 req_addr,
    input  logic [DATA_W-1:0]                 req_data,
    input  logic [DATA_W/8-1:0]               req_sel,
    output logic                              wb_cyc_o,
    output logic                              wb_stb_o,
    output logic                              wb_we_o,
    output logic [ADDR_W-1:0]                 wb_adr_o,
    output logic [DATA_W-1:0]                 wb_dat_o,
    output logic [DATA_W/8-1:0]               wb_sel_o,
    input  logic                              wb_ack_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              busy,
    output logic                              timeout_err,
    input  logic                              err_clr
);

    localparam int SEL_W = DATA_W / 8;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    state_t             state;
    logic [15:0]        wait_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;

    logic [ADDR_W-1:0]  adr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0]  dat_mem [FIFO_DEPTH];
    logic [SEL_W-1:0]   sel_mem [FIFO_DEPTH];

    // Handshake: a request transfers on any rising edge where req_valid and req_ready
    // are both high; req_ready depends only on the registered level, so a full FIFO
    // refuses a push even in a cycle where the FSM pops.
    always_comb begin
        req_ready = (fifo_level != LVL_W'(FIFO_DEPTH));
        push      = req_valid & req_ready;
        pop       = (state == IDLE) && (fifo_level != '0);
        busy      = (fifo_level != '0) | wb_cyc_o;
        wb_stb_o  = wb_cyc_o;
        wb_we_o   = wb_cyc_o;
    end

    always_ff @(posedge clk_100MHz) begin
        if (push) begin
            adr_mem[wr_ptr] <= req_addr;
            dat_mem[wr_ptr] <= req_data;
            sel_mem[wr_ptr] <= req_sel;
        end
    end

    // Depth is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            wb_cyc_o    <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (err_clr) timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        wb_adr_o <= adr_mem[rd_ptr];
                        wb_dat_o <= dat_mem[rd_ptr];
                        wb_sel_o <= sel_mem[rd_ptr];
                        wb_cyc_o <= 1'b1;
                        wait_cnt <= '0;
                        state    <= BUS;
                    end
                end
                BUS: begin
                    // An ack arriving in the final wait cycle still counts as success.
                    if (wb_ack_i) begin
                        wb_cyc_o <= 1'b0;
                        state    <= IDLE;
                    end else if (wait_cnt == 16'(TIMEOUT - 1)) begin
                        wb_cyc_o    <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_wb_writer.sv
// Directed and randomized bench for vram_wb_writer: a queue-based model of accepted
// requests is compared against every Wishbone cycle the DUT starts.
module tb_vram_wb_writer;

    localparam int ADDR_W  = 27;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 255;
    localparam int W       = ADDR_W + DATA_W + SEL_W;

    logic              clk_100MHz = 1'b0;
    logic              reset_n;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic [SEL_W-1:0]  req_sel;
    logic              wb_cyc_o, wb_stb_o, wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [DATA_W-1:0] wb_dat_o;
    logic [SEL_W-1:0]  wb_sel_o;
    logic              wb_ack_i;
    logic [3:0]        fifo_level;
    logic              busy;
    logic              timeout_err;
    logic              err_clr;

    vram_wb_writer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_100MHz(clk_100MHz), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .fifo_level(fifo_level), .busy(busy),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    int rise_t[$];
    int cyc_n = 0;
    int bus_cyc = 0;
    int last_len = 0;
    int writes = 0;
    int ack_mode = 0;   // 0: never ack, 1: ack once bus_cyc >= ack_at, 2: random
    int ack_at = 1;
    logic [W-1:0] cur;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_100MHz);
        #1;
    endtask

    task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input logic [SEL_W-1:0] s);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_sel   = s;
        while (!req_ready && n < 2000) begin
            step();
            n++;
        end
        if (!req_ready) begin
            chk("push_bound", 64'(req_ready), 64'd1);
        end else begin
            exp_q.push_back({a, d, s});
            step();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk(tag, 64'(busy), 64'd0);
    endtask

    // Slave model and bus monitor: each new cycle must carry the oldest accepted request.
    always @(negedge clk_100MHz) begin
        cyc_n++;
        if (!wb_cyc_o) begin
            if (bus_cyc != 0) last_len = bus_cyc;
            bus_cyc  = 0;
            wb_ack_i = 1'b0;
        end else begin
            if (bus_cyc == 0) begin
                writes++;
                rise_t.push_back(cyc_n);
                cur = {wb_adr_o, wb_dat_o, wb_sel_o};
                chk("wr_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) chk("wr_entry", 64'(cur), 64'(exp_q.pop_front()));
            end else begin
                chk("wr_stable", 64'({wb_adr_o, wb_dat_o, wb_sel_o}), 64'(cur));
            end
            chk("stb_we", 64'({wb_stb_o, wb_we_o}), 64'd3);
            bus_cyc++;
            case (ack_mode)
                0:       wb_ack_i = 1'b0;
                1:       wb_ack_i = (bus_cyc >= ack_at);
                default: wb_ack_i = ($urandom_range(0, 3) == 0);
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int n;
        int pushed;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_sel   = '0;
        wb_ack_i  = 1'b0;
        err_clr   = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_cyc", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
        chk("rst_bus", 64'({wb_adr_o, wb_dat_o, wb_sel_o}), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(timeout_err), 64'd0);
        reset_n = 1'b1;
        step();
        chk("rst_ready", 64'(req_ready), 64'd1);

        // Single write, ack on the third bus cycle
        ack_mode = 1;
        ack_at   = 3;
        push(27'h0000100, 32'hDEADBEEF, 4'hF);
        chk("single_level", 64'(fifo_level), 64'd1);
        step();
        chk("single_cyc", 64'(wb_cyc_o), 64'd1);
        wait_idle("single_drain", 50);
        chk("single_len", 64'(last_len), 64'd3);
        chk("single_writes", 64'(writes), 64'd1);

        // Fill: one on the bus plus a full FIFO, then drain with ack every cycle
        ack_mode = 0;
        rise_t.delete();
        for (int i = 0; i < 9; i++) push(27'(32'h1000 + i), $urandom, 4'(i + 1));
        chk("full_level", 64'(fifo_level), 64'd8);
        chk("full_ready", 64'(req_ready), 64'd0);
        chk("full_cyc", 64'(wb_cyc_o), 64'd1);
        ack_mode = 1;
        ack_at   = 1;
        push(27'h7FFFFFF, 32'h0BADF00D, 4'h5);
        wait_idle("full_drain", 100);
        chk("full_count", 64'(rise_t.size()), 64'd10);
        if (rise_t.size() == 10) chk("full_rate", 64'(rise_t[9] - rise_t[1]), 64'd16);

        // Timeout abort, next entry issues, err_clr clears the flag
        ack_mode = 0;
        w0 = writes;
        push(27'h0000200, 32'h11111111, 4'h3);
        push(27'h0000204, 32'h22222222, 4'hC);
        n = 0;
        while (!timeout_err && n < 400) begin
            step();
            n++;
        end
        chk("to_err", 64'(timeout_err), 64'd1);
        chk("to_len", 64'(last_len), 64'(TIMEOUT));
        ack_mode = 1;
        wait_idle("to_drain", 50);
        chk("to_writes", 64'(writes - w0), 64'd2);
        chk("to_err_sticky", 64'(timeout_err), 64'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("to_err_clr", 64'(timeout_err), 64'd0);

        // Reset in the middle of a bus cycle with three entries queued
        ack_mode = 0;
        for (int i = 0; i < 4; i++) push(27'(32'h3000 + i), $urandom, 4'hA);
        step();
        chk("mid_level", 64'(fifo_level), 64'd3);
        chk("mid_cyc", 64'(wb_cyc_o), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cyc", 64'({wb_cyc_o, wb_stb_o, wb_we_o}), 64'd0);
        chk("mid_rst_level", 64'(fifo_level), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        step();
        reset_n = 1'b1;
        w0 = writes;
        for (int i = 0; i < 20; i++) step();
        chk("mid_no_stale", 64'(writes - w0), 64'd0);
        chk("mid_ready", 64'(req_ready), 64'd1);

        // Random push/ack stress
        ack_mode = 2;
        w0 = writes;
        pushed = 0;
        for (int i = 0; i < 150; i++) begin
            n = $urandom_range(0, 3);
            for (int j = 0; j < n; j++) step();
            push(27'($urandom), $urandom, 4'($urandom));
            pushed++;
        end
        wait_idle("rand_drain", 2000);
        chk("rand_count", 64'(writes - w0), 64'(pushed));
        chk("rand_q_empty", 64'(exp_q.size()), 64'd0);
        chk("rand_err", 64'(timeout_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
